// File: rtl/bsr_pkg.sv
// Shared types and sizing helpers for the round-robin binary-search scheduler.
// Optional watchdog is enabled by defining BSR_TIMEOUT_EN.
package bsr_pkg;

  typedef enum logic [1:0] {
    S_ARB     = 2'd0,
    S_LAUNCH  = 2'd1,
    S_RELEASE = 2'd2,
    S_RESP    = 2'd3
  } bsr_state_e;

  localparam int unsigned BSR_NUM_REQ     = 4;
  localparam int unsigned BSR_DATA_W      = 8;
  localparam int unsigned BSR_ADDR_W      = 5;
  localparam int unsigned BSR_TIMEOUT_CYC = 128;

  // Width of a requester index; never below one bit.
  function automatic int unsigned bsr_id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsr_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr, wrapping.
module bsr_rr_pick
  import bsr_pkg::*;
#(
  parameter int unsigned NUM_REQ = BSR_NUM_REQ,
  parameter int unsigned ID_W    = bsr_id_w(BSR_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] sel;

  // Scan from ptr upward, taking the first asserted request.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    sel    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sel = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!any && req[sel]) begin
        onehot[sel] = 1'b1;
        idx         = sel;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsearch_rr_scheduler.sv
// Round-robin scheduler sharing one binary-search engine among NUM_REQ clients.
// Define BSR_TIMEOUT_EN to enable the LAUNCH watchdog (rsp_err on expiry).
module bsearch_rr_scheduler
  import bsr_pkg::*;
#(
  parameter int unsigned NUM_REQ     = BSR_NUM_REQ,
  parameter int unsigned DATA_W      = BSR_DATA_W,
  parameter int unsigned ADDR_W      = BSR_ADDR_W,
  parameter int unsigned TIMEOUT_CYC = BSR_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_target,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rsp_valid,
  output logic [bsr_id_w(NUM_REQ)-1:0] rsp_id,
  output logic                      rsp_found,
  output logic [ADDR_W-1:0]         rsp_addr,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      eng_start,
  output logic [DATA_W-1:0]         eng_A,
  output logic                      eng_clr,
  input  logic                      eng_done,
  input  logic                      eng_found,
  input  logic [ADDR_W-1:0]         eng_addr
);

  localparam int unsigned ID_W = bsr_id_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("bsearch_rr_scheduler: unsupported parameter set");
  end

  bsr_state_e state_q, state_d;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic               rsp_valid_d;
  logic [ID_W-1:0]    id_d;
  logic               found_d;
  logic [ADDR_W-1:0]  addr_d;
  logic               busy_d;
  logic               start_d;
  logic [DATA_W-1:0]  eng_a_d;
  logic               clr_d;
  logic               clr_pend_q;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  tgt_arr [NUM_REQ];

  // Unpack per-requester targets.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_tgt
    assign tgt_arr[g] = req_target[g*DATA_W +: DATA_W];
  end

  bsr_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef BSR_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Next-state and next-output decode; all outputs are registered from these.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt;
    rsp_valid_d = 1'b0;
    id_d        = rsp_id;
    found_d     = rsp_found;
    addr_d      = rsp_addr;
    busy_d      = 1'b1;
    start_d     = 1'b0;
    eng_a_d     = eng_A;
    clr_d       = 1'b0;
`ifdef BSR_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      S_ARB: begin
        busy_d = 1'b0;
        gnt_d  = '0;
        if (pick_any) begin
          state_d = S_LAUNCH;
          gnt_d   = pick_onehot;
          id_d    = pick_idx;
          eng_a_d = tgt_arr[pick_idx];
          ptr_d   = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
          found_d = 1'b0;
          addr_d  = '0;
          busy_d  = 1'b1;
          start_d = 1'b1;
`ifdef BSR_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_LAUNCH: begin
        start_d = 1'b1;
        if (eng_done) begin
          state_d = S_RELEASE;
          start_d = 1'b0;
          found_d = eng_found;
          addr_d  = eng_addr;
        end
`ifdef BSR_TIMEOUT_EN
        else if (cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d     = S_RESP;
          start_d     = 1'b0;
          clr_d       = 1'b1;
          rsp_valid_d = 1'b1;
          found_d     = 1'b0;
          addr_d      = '0;
          err_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
`endif
      end
      S_RELEASE: begin
        if (!eng_done) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_ARB;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_ARB;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, pointer and registered output update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_ARB;
      ptr_q      <= '0;
      gnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_found  <= 1'b0;
      rsp_addr   <= '0;
      busy       <= 1'b0;
      eng_start  <= 1'b0;
      eng_A      <= '0;
      eng_clr    <= 1'b0;
      clr_pend_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt        <= gnt_d;
      rsp_valid  <= rsp_valid_d;
      rsp_id     <= id_d;
      rsp_found  <= found_d;
      rsp_addr   <= addr_d;
      busy       <= busy_d;
      eng_start  <= start_d;
      eng_A      <= eng_a_d;
      eng_clr    <= clr_d | clr_pend_q;
      clr_pend_q <= 1'b0;
    end
  end

`ifdef BSR_TIMEOUT_EN
  // Watchdog counter and error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_bsearch_rr_scheduler.sv
// Randomized self-checking bench for bsearch_rr_scheduler with a behavioural search engine.
module tb_bsearch_rr_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 5;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_target;
  logic [NUM_REQ-1:0]        gnt;
  logic                      rsp_valid;
  logic [1:0]                rsp_id;
  logic                      rsp_found;
  logic [ADDR_W-1:0]         rsp_addr;
  logic                      rsp_err;
  logic                      busy;
  logic                      eng_start;
  logic [DATA_W-1:0]         eng_A;
  logic                      eng_clr;
  logic                      eng_done;
  logic                      eng_found;
  logic [ADDR_W-1:0]         eng_addr;

  int errors = 0;
  int checks = 0;

  logic [7:0] tgt [NUM_REQ];
  int         ptr_m;
  bit         eng_hang;

  always #5 clk = ~clk;

  bsearch_rr_scheduler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_target (req_target),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_found  (rsp_found),
    .rsp_addr   (rsp_addr),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .eng_start  (eng_start),
    .eng_A      (eng_A),
    .eng_clr    (eng_clr),
    .eng_done   (eng_done),
    .eng_found  (eng_found),
    .eng_addr   (eng_addr)
  );

  // Sorted RAM contents: value at address i is 7*i+1 (0x40 lives at address 9).
  function automatic logic [7:0] ram_at(input int i);
    return 8'(i * 7 + 1);
  endfunction

  function automatic void ref_find(input logic [7:0] t, output bit f, output logic [4:0] a);
    f = 1'b0;
    a = '0;
    for (int i = 0; i < 32; i++) begin
      if (ram_at(i) == t) begin
        f = 1'b1;
        a = 5'(i);
      end
    end
  endfunction

  // Round-robin rule: first requester at or after ptr, wrapping.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (p + k) % NUM_REQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // Behavioural engine: random latency, done held until start drops.
  int         e_cnt;
  bit         e_run;
  logic [7:0] e_tgt;
  always @(posedge clk or negedge reset_n) begin
    bit         f;
    logic [4:0] a;
    if (!reset_n) begin
      eng_done  <= 1'b0;
      eng_found <= 1'b0;
      eng_addr  <= '0;
      e_run     <= 1'b0;
      e_cnt     <= 0;
    end else if (eng_clr) begin
      eng_done <= 1'b0;
      e_run    <= 1'b0;
    end else if (e_run) begin
      if (e_cnt == 0) begin
        if (!eng_hang) begin
          ref_find(e_tgt, f, a);
          eng_done  <= 1'b1;
          eng_found <= f;
          eng_addr  <= a;
          e_run     <= 1'b0;
        end
      end else begin
        e_cnt <= e_cnt - 1;
      end
    end else if (eng_done) begin
      if (!eng_start) eng_done <= 1'b0;
    end else if (eng_start) begin
      e_run <= 1'b1;
      e_cnt <= int'($urandom_range(0, 5));
      e_tgt <= eng_A;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_targets();
    req_target = {tgt[3], tgt[2], tgt[1], tgt[0]};
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (gnt != '0) ok = 1'b1;
    end
    if (!ok) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
  endtask

  task automatic check_rsp(input string tag, input int w, input logic [7:0] t);
    bit         f;
    logic [4:0] a;
    ref_find(t, f, a);
    check({tag, "_id"}, 32'(rsp_id), 32'(w));
    check({tag, "_found"}, 32'(rsp_found), 32'(f));
    if (f) check({tag, "_addr"}, 32'(rsp_addr), 32'(a));
    check({tag, "_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_gnt"}, 32'(gnt), 32'(1 << w));
  endtask

  // One isolated transaction; optional target scramble / req drop after grant.
  task automatic do_txn(input string tag, input logic [3:0] r, input bit scramble, input bit drop);
    int         w;
    logic [7:0] t;
    bit         ok;
    w     = rr_pick(r, ptr_m);
    ptr_m = (w + 1) % NUM_REQ;
    t     = tgt[w];
    drive_targets();
    req = r;
    wait_gnt(ok);
    if (ok) begin
      check({tag, "_grant"}, 32'(gnt), 32'(1 << w));
      check({tag, "_busy"}, 32'(busy), 32'd1);
    end
    if (scramble) begin
      for (int i = 0; i < NUM_REQ; i++) tgt[i] = 8'($urandom);
      drive_targets();
    end
    if (drop) req = '0;
    wait_rsp(200, ok);
    if (!ok) check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
    else check_rsp(tag, w, t);
    req = '0;
    @(negedge clk);
    check({tag, "_rsp_1cyc"}, 32'(rsp_valid), 32'd0);
    check({tag, "_gnt_rel"}, 32'(gnt), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Requests held continuously for n transactions.
  task automatic held_seq(input string tag, input logic [3:0] r, input int n);
    int  w;
    bit  ok;
    logic [7:0] t;
    drive_targets();
    req = r;
    for (int k = 0; k < n; k++) begin
      w     = rr_pick(r, ptr_m);
      ptr_m = (w + 1) % NUM_REQ;
      t     = tgt[w];
      wait_rsp(200, ok);
      if (!ok) begin
        check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
        break;
      end
      check_rsp(tag, w, t);
      if (k == n - 1) req = '0;
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit ok;
    int n;
    reset_n    = 1'b0;
    req        = '0;
    req_target = '0;
    eng_hang   = 1'b0;
    ptr_m      = 0;
    for (int i = 0; i < NUM_REQ; i++) tgt[i] = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(eng_start), 32'd0);
    check("rst_rsp", 32'(rsp_valid), 32'd0);
    check("rst_engA", 32'(eng_A), 32'd0);
    check("rst_clr", 32'(eng_clr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("clr_pulse", 32'(eng_clr), 32'd1);
    @(negedge clk);
    check("clr_end", 32'(eng_clr), 32'd0);

    // All requesters held: grants rotate 0,1,2,3,0,1,2,3.
    for (int i = 0; i < NUM_REQ; i++) tgt[i] = ram_at(i * 5 + 2);
    held_seq("all4", 4'b1111, 8);

    // Single requester 2, present and absent targets.
    tgt[2] = 8'h40;
    do_txn("hit40", 4'b0100, 1'b0, 1'b0);
    tgt[2] = 8'h41;
    do_txn("miss41", 4'b0100, 1'b0, 1'b0);

    // Pointer now 3: requests 3 and 0 give 3 then 0 (wrap).
    tgt[0] = ram_at(30);
    tgt[3] = 8'h02;
    held_seq("wrap", 4'b1001, 2);

    // Randomized transactions.
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NUM_REQ; i++)
        tgt[i] = ($urandom_range(0, 1) == 1) ? ram_at(int'($urandom_range(0, 31))) : 8'($urandom);
      do_txn("rand", 4'($urandom_range(1, 15)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    // Reset while the engine is mid-search.
    eng_hang = 1'b1;
    tgt[1]   = 8'h08;
    drive_targets();
    req = 4'b0010;
    wait_gnt(ok);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_start", 32'(eng_start), 32'd0);
    check("midrst_rsp", 32'(rsp_valid), 32'd0);
    req      = '0;
    eng_hang = 1'b0;
    ptr_m    = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_clr", 32'(eng_clr), 32'd1);
    check("midrst_norsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("midrst_clr_end", 32'(eng_clr), 32'd0);

    // After reset the pointer is back at 0.
    tgt[0] = ram_at(3);
    tgt[2] = ram_at(4);
    do_txn("post_rst", 4'b0101, 1'b0, 1'b0);

    // Engine never finishes.
    eng_hang = 1'b1;
    tgt[3]   = 8'h40;
    drive_targets();
    req = 4'b1000;
    wait_gnt(ok);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) ok = 1'b1;
    end
`ifdef BSR_TIMEOUT_EN
    check("wd_rsp", 32'(ok), 32'd1);
    check("wd_lat", 32'(n), 32'd128);
    check("wd_err", 32'(rsp_err), 32'd1);
    check("wd_found", 32'(rsp_found), 32'd0);
    check("wd_addr", 32'(rsp_addr), 32'd0);
    check("wd_id", 32'(rsp_id), 32'd3);
`else
    check("hang_norsp", 32'(ok), 32'd0);
    check("hang_busy", 32'(busy), 32'd1);
    check("hang_start", 32'(eng_start), 32'd1);
    check("hang_err", 32'(rsp_err), 32'd0);
`endif
    req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
